// File: rtl/mfcc_frame_sched.sv
// Frame scheduler: walks a sample RAM in overlapping frames and streams
// each frame to the MFCC core once it signals it can take a whole frame.
module mfcc_frame_sched #(
   parameter int ADDR_W      = 15,
   parameter int DATA_W      = 16,
   parameter int NUM_SAMPLES = 16384
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              fs_control,
   input  logic              fe_ready,
   input  logic [DATA_W-1:0] ram_data,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] smp_data,
   output logic              smp_valid,
   output logic              frame_start,
   output logic              frame_last,
   output logic [7:0]        frame_idx,
   output logic              busy,
   output logic              done
);

   localparam int AW1 = ADDR_W + 1;

   typedef enum logic [2:0] {
      IDLE, WAIT_RDY, READ, DRAIN, NEXT, FIN
   } state_t;

   state_t            state_q, state_d;
   logic              len_sel_q, len_sel_d;
   logic [AW1-1:0]    base_q, base_d;
   logic [AW1-1:0]    cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        idx_q, idx_d;
   logic              rd_q, rd_d;
   logic              rd_fst_q, rd_fst_d;
   logic              rd_lst_q, rd_lst_d;
   logic              vld_q, fst_q, lst_q;

   logic [AW1-1:0]    frame_len;
   logic [AW1-1:0]    hop_len;
   logic [AW1-1:0]    base_nxt;

   assign frame_len = len_sel_q ? AW1'(256) : AW1'(128);
   assign hop_len   = len_sel_q ? AW1'(128) : AW1'(64);
   assign base_nxt  = base_q + hop_len;

   always_comb begin
      state_d   = state_q;
      len_sel_d = len_sel_q;
      base_d    = base_q;
      cnt_d     = cnt_q;
      addr_d    = addr_q;
      idx_d     = idx_q;
      rd_d      = 1'b0;
      rd_fst_d  = 1'b0;
      rd_lst_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start) begin
               len_sel_d = fs_control;
               base_d    = '0;
               idx_d     = '0;
               state_d   = WAIT_RDY;
            end
         end
         WAIT_RDY: begin
            if (fe_ready) begin
               cnt_d   = '0;
               state_d = READ;
            end
         end
         READ: begin
            addr_d   = ADDR_W'(base_q + cnt_q);
            rd_d     = 1'b1;
            rd_fst_d = (cnt_q == '0);
            rd_lst_d = (cnt_q == frame_len - AW1'(1));
            cnt_d    = cnt_q + AW1'(1);
            if (rd_lst_d) state_d = DRAIN;
         end
         DRAIN: state_d = NEXT;
         NEXT: begin
            base_d = base_nxt;
            // compared at ADDR_W+1 bits so the end test cannot wrap
            if (base_nxt + frame_len > AW1'(NUM_SAMPLES)) begin
               state_d = FIN;
            end else begin
               idx_d   = idx_q + 8'd1;
               state_d = WAIT_RDY;
            end
         end
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         len_sel_q <= 1'b0;
         base_q    <= '0;
         cnt_q     <= '0;
         addr_q    <= '0;
         idx_q     <= '0;
         rd_q      <= 1'b0;
         rd_fst_q  <= 1'b0;
         rd_lst_q  <= 1'b0;
         vld_q     <= 1'b0;
         fst_q     <= 1'b0;
         lst_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         len_sel_q <= len_sel_d;
         base_q    <= base_d;
         cnt_q     <= cnt_d;
         addr_q    <= addr_d;
         idx_q     <= idx_d;
         rd_q      <= rd_d;
         rd_fst_q  <= rd_fst_d;
         rd_lst_q  <= rd_lst_d;
         vld_q     <= rd_q;
         fst_q     <= rd_fst_q;
         lst_q     <= rd_lst_q;
      end
   end

   // RAM data lands one cycle after the registered address
   assign ram_addr    = addr_q;
   assign smp_valid   = vld_q;
   assign smp_data    = vld_q ? ram_data : '0;
   assign frame_start = vld_q & fst_q;
   assign frame_last  = vld_q & lst_q;
   assign frame_idx   = idx_q;
   assign busy        = (state_q != IDLE);
   assign done        = (state_q == FIN);

endmodule

// File: tb/tb_mfcc_frame_sched.sv
// Directed bench for mfcc_frame_sched: a sample monitor checks every
// emitted sample against address/flag/index values computed here.
module tb_mfcc_frame_sched;

   localparam int AW = 15;
   localparam int DW = 16;
   localparam int NS = 16384;

   logic          clk = 1'b0;
   logic          rst_n = 1'b1;
   logic          start = 1'b0;
   logic          fs_control = 1'b0;
   logic          fe_ready = 1'b1;
   logic [DW-1:0] ram_data = '0;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] smp_data;
   logic          smp_valid;
   logic          frame_start;
   logic          frame_last;
   logic [7:0]    frame_idx;
   logic          busy;
   logic          done;

   int n_chk = 0;
   int n_err = 0;

   mfcc_frame_sched #(
      .ADDR_W(AW), .DATA_W(DW), .NUM_SAMPLES(NS)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .fs_control(fs_control), .fe_ready(fe_ready),
      .ram_data(ram_data), .ram_addr(ram_addr),
      .smp_data(smp_data), .smp_valid(smp_valid),
      .frame_start(frame_start), .frame_last(frame_last),
      .frame_idx(frame_idx), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] f(input logic [AW-1:0] a);
      return {1'b0, a} * 16'd7 + 16'd3;
   endfunction

   always @(posedge clk) ram_data <= f(ram_addr);

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   bit            mon_on = 1'b0;
   int            fl, hop, exp_k, exp_n;
   int            frames_seen, done_cnt, max_addr;
   logic [DW-1:0] last_start_data, f1_data;
   logic [7:0]    ek;
   logic [DW-1:0] ed;

   task automatic arm(input int len, input int h);
      fl = len; hop = h; exp_k = 0; exp_n = 0;
      frames_seen = 0; done_cnt = 0; max_addr = 0;
      last_start_data = '0; f1_data = '0;
      mon_on = 1'b1;
   endtask

   always @(negedge clk) begin
      if (mon_on) begin
         if (done) done_cnt++;
         if (int'(ram_addr) > max_addr) max_addr = int'(ram_addr);
         if (smp_valid) begin
            ek = 8'(exp_k);
            ed = f(AW'(exp_k * hop + exp_n));
            check("sample",
                  {frame_idx, frame_start, frame_last, smp_data},
                  {ek, exp_n == 0, exp_n == fl - 1, ed});
            if (frame_start) last_start_data = smp_data;
            if (frame_start && exp_k == 1) f1_data = smp_data;
            exp_n++;
            if (exp_n == fl) begin
               exp_n = 0;
               exp_k++;
               frames_seen++;
            end
         end
      end
   end

   function automatic logic [63:0] outs();
      return {20'd0, ram_addr, smp_data, smp_valid, frame_start,
              frame_last, frame_idx, busy, done};
   endfunction

   task automatic pulse_start();
      @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
   endtask

   task automatic wait_idle();
      int i = 0;
      while (busy && i < 40000) begin
         @(negedge clk);
         i++;
      end
      check("run_end_idle", {63'd0, busy}, 64'd0);
   endtask

   int lat;
   bit hit;

   initial begin
      #2 rst_n = 1'b0;
      #1 check("reset_outs", outs(), 64'd0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      // first frames, then asynchronous reset inside frame 2
      fs_control = 1'b1;
      arm(256, 128);
      pulse_start();
      lat = 1;
      while (!smp_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check("first_valid_lat", 64'(lat), 64'd4);
      hit = 0;
      for (int i = 0; i < 2000 && !hit; i++) begin
         @(negedge clk);
         hit = smp_valid && frame_start && frame_idx == 8'd2;
      end
      check("reach_frame2", {63'd0, hit}, 64'd1);
      repeat (10) @(negedge clk);
      check("busy_in_read", {63'd0, busy}, 64'd1);
      check("frames_before_rst", 64'(frames_seen), 64'd2);
      #2 rst_n = 1'b0;
      #1 check("reset_async", outs(), 64'd0);
      mon_on = 1'b0;
      repeat (4) begin
         @(negedge clk);
         check("rst_quiet", {62'd0, smp_valid, busy}, 64'd0);
      end
      rst_n = 1'b1;
      repeat (3) begin
         @(negedge clk);
         check("post_rst_idle", {62'd0, smp_valid, busy}, 64'd0);
      end

      // full run, 256/128 framing, fe_ready tied high
      arm(256, 128);
      pulse_start();
      wait_idle();
      check("l256_frames", 64'(frames_seen), 64'd127);
      check("l256_done", 64'(done_cnt), 64'd1);
      check("l256_idx", 64'(frame_idx), 64'd126);
      check("l256_f1", 64'(f1_data), 64'(f(AW'(128))));
      check("l256_lastbase", 64'(last_start_data), 64'(f(AW'(16128))));
      check("l256_maxaddr", 64'(max_addr), 64'(NS - 1));

      // 128/64 framing with stall before frame 3, stray start in frame 5
      fs_control = 1'b0;
      arm(128, 64);
      pulse_start();
      hit = 0;
      for (int i = 0; i < 2000 && !hit; i++) begin
         @(negedge clk);
         hit = smp_valid && frame_last && frame_idx == 8'd2;
      end
      check("reach_f2_last", {63'd0, hit}, 64'd1);
      fe_ready = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         check("stall_no_valid", {63'd0, smp_valid}, 64'd0);
      end
      check("stall_idx", 64'(frame_idx), 64'd3);
      fe_ready = 1'b1;
      hit = 0;
      for (int i = 0; i < 2000 && !hit; i++) begin
         @(negedge clk);
         hit = smp_valid && frame_start && frame_idx == 8'd5;
      end
      check("reach_frame5", {63'd0, hit}, 64'd1);
      start = 1'b1;
      fs_control = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_idle();
      mon_on = 1'b0;
      check("l128_frames", 64'(frames_seen), 64'd255);
      check("l128_done", 64'(done_cnt), 64'd1);
      check("l128_idx", 64'(frame_idx), 64'd254);
      check("l128_lastbase", 64'(last_start_data), 64'(f(AW'(16256))));
      check("l128_maxaddr", 64'(max_addr), 64'(NS - 1));
      repeat (3) @(negedge clk);
      check("final_idle", {62'd0, busy, done}, 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/mfcc_frame_sched.md
MFCC_FRAME_SCHED -- requirements
Module: mfcc_frame_sched

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 15, RAM address width; DATA_W, default 16, sample width; NUM_SAMPLES, default 16384, samples stored in RAM.
REQ-002 Port clk  in  1  single clock; all state updates on its rising edge.
REQ-003 Port rst_n  in  1  reset, asynchronous, active-low.
REQ-004 Port start  in  1  one-cycle request to begin a framing run; honoured only in IDLE.
REQ-005 Port fs_control  in  1  frame-size select: 1 = 256-sample frame / 128 hop, 0 = 128-sample frame / 64 hop.
REQ-006 Port fe_ready  in  1  MFCC core can accept a complete new frame.
REQ-007 Port ram_data  in  DATA_W  synchronous RAM read data, valid one cycle after ram_addr.
REQ-008 Port ram_addr  out  ADDR_W  RAM read address.
REQ-009 Port smp_data  out  DATA_W  sample to MFCC core.
REQ-010 Port smp_valid  out  1  smp_data valid this cycle.
REQ-011 Port frame_start  out  1  asserted with first valid sample of a frame.
REQ-012 Port frame_last  out  1  asserted with last valid sample of a frame.
REQ-013 Port frame_idx  out  8  index of the current frame, 0-based.
REQ-014 Port busy  out  1  high in every state except IDLE.
REQ-015 Port done  out  1  one-cycle pulse when the run completes.

Function
REQ-016 FSM states SHALL be IDLE, WAIT_RDY, READ, DRAIN, NEXT, FIN.
REQ-017 IDLE: on start=1 SHALL latch fs_control into len_sel, clear base and frame_idx to 0, go to WAIT_RDY.
REQ-018 fs_control changes after the start cycle SHALL have no effect until the next run.
REQ-019 WAIT_RDY: SHALL hold until fe_ready=1, then clear sample counter cnt and go to READ.
REQ-020 READ: ram_addr SHALL equal base+cnt each cycle; cnt increments by 1; when cnt = FRAME_LEN-1 go to DRAIN.
REQ-021 smp_valid SHALL be the one-cycle-delayed READ indicator; smp_data SHALL equal ram_data on that cycle (read latency 1).
REQ-022 Within a frame, samples SHALL be emitted on FRAME_LEN consecutive cycles with no gaps; fe_ready is not sampled mid-frame.
REQ-023 frame_start SHALL be high with the sample from cnt=0; frame_last with the sample from cnt=FRAME_LEN-1; both qualified by smp_valid.
REQ-024 DRAIN: emits the last sample; go to NEXT.
REQ-025 NEXT: base += HOP_LEN; if new base + FRAME_LEN > NUM_SAMPLES go to FIN, else increment frame_idx and go to WAIT_RDY.
REQ-026 FIN: done=1 for exactly one cycle, then IDLE; frame_idx holds the last frame's index until the next start.
REQ-027 Address arithmetic SHALL be computed at ADDR_W+1 bits so the end-of-data comparison cannot wrap; ram_addr never exceeds NUM_SAMPLES-1.
REQ-028 start asserted while busy=1 SHALL be ignored.
REQ-029 Frame counts: len_sel=1 -> 127 frames (bases 0..16128); len_sel=0 -> 255 frames (bases 0..16256).
REQ-030 ram_addr SHALL hold its last value outside READ.

Reset
REQ-031 rst_n=0 SHALL immediately force IDLE, ram_addr=0, smp_data=0, smp_valid=0, frame_start=0, frame_last=0, frame_idx=0, busy=0, done=0, regardless of clock.
REQ-032 Reset mid-frame SHALL abort the run with no further smp_valid; after release the block waits for a new start.

Verification
REQ-033 fs_control=1, start pulse, fe_ready=1 -> first smp_valid 2 cycles after entering READ, addresses 0..255, frame_start with addr 0 data, frame_last with addr 255 data.
REQ-034 Full run, fs_control=1, fe_ready tied high -> 127 frames, frame 1 starts at addr 128, final frame_idx=126, single done pulse, busy low afterwards.
REQ-035 fs_control=0 run, fe_ready held low 50 cycles before frame 3 -> no smp_valid during stall, 255 frames total, last base 16256.
REQ-036 start pulsed during frame 5, fs_control toggled mid-run -> ignored; frame length unchanged, frame_idx continues.
REQ-037 rst_n low during READ of frame 2 -> outputs at reset values asynchronously; after release, start runs from base 0, frame_idx 0.
